// File: rtl/count_chk_pkg.sv
// count_chk_pkg: shared state encoding and counter constants for the count sequence checker
package count_chk_pkg;
    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SAT_MAX = 8'd255;
endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: saturating up-counter with synchronous clear taking priority over increment
module sat_cnt #(
    parameter int W = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] base;
    // clear first so a same-edge clear and increment lands on 1
    always_comb base = clr ? '0 : cnt;
    // count up from the cleared base, holding at MAX
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else cnt <= (inc && base != MAX) ? base + W'(1) : base;
endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: watches a counter's samples, locks onto a correct increment run and flags breaks
module count_seq_checker import count_chk_pkg::*; #(
    parameter int WIDTH = 4,
    parameter int LOCK_LEN = 2,
    parameter int ALLOW_RESTART = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             valid,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             restart_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0] expected
);
    localparam logic [3:0] LOCK_N = 4'(LOCK_LEN);
    state_t state, state_d;
    logic [2:0] run, run_d;
    logic [3:0] run_nx;
    logic hit, err_d, restart_d, wrap_d;
    assign hit = q_in == expected;
    assign run_nx = {1'b0, run} + 4'd1;
    assign locked = state == LOCKED;
    // next state, run length and event decode for the current sample
    always_comb begin
        state_d = state;
        run_d = run;
        err_d = 1'b0;
        restart_d = 1'b0;
        wrap_d = 1'b0;
        if (valid)
            case (state)
                IDLE: begin
                    state_d = SYNC;
                    run_d = '0;
                end
                SYNC: begin
                    run_d = hit ? run_nx[2:0] : '0;
                    wrap_d = hit && q_in == '0;
                    state_d = (hit && run_nx >= LOCK_N) ? LOCKED : SYNC;
                end
                LOCKED: begin
                    wrap_d = hit && q_in == '0;
                    restart_d = !hit && ALLOW_RESTART != 0 && q_in == '0;
                    err_d = !hit && !restart_d;
                    run_d = err_d ? '0 : run;
                    state_d = err_d ? SYNC : LOCKED;
                end
                default: state_d = IDLE;
            endcase
    end
    // every accepted sample re-anchors expected to sample+1, which covers match, restart and error alike
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            run <= '0;
            expected <= '0;
            wrap_cnt <= '0;
            err_pulse <= 1'b0;
            restart_pulse <= 1'b0;
        end else begin
            state <= state_d;
            run <= run_d;
            if (valid) expected <= q_in + WIDTH'(1);
            if (wrap_d) wrap_cnt <= wrap_cnt + 8'd1;
            err_pulse <= err_d;
            restart_pulse <= restart_d;
        end
    sat_cnt #(.W(CNT_W), .MAX(SAT_MAX)) u_err (
        .clk(clk),
        .reset(reset),
        .clr(clr_err),
        .inc(err_d),
        .cnt(err_cnt)
    );
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed self-checking bench for count_seq_checker
module tb_count_seq_checker;
    logic clk = 1'b0;
    logic reset, valid, clr_err;
    logic [3:0] q_in;
    logic locked, err_pulse, restart_pulse;
    logic [7:0] err_cnt, wrap_cnt;
    logic [3:0] expected;
    int checks = 0;
    int errors = 0;

    count_seq_checker dut (
        .clk(clk),
        .reset(reset),
        .q_in(q_in),
        .valid(valid),
        .clr_err(clr_err),
        .locked(locked),
        .err_pulse(err_pulse),
        .restart_pulse(restart_pulse),
        .err_cnt(err_cnt),
        .wrap_cnt(wrap_cnt),
        .expected(expected)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send(input logic [3:0] v);
        q_in = v;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if ({locked, err_pulse, restart_pulse, err_cnt, wrap_cnt, expected} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state: got locked=%b ep=%b rp=%b err=%0d wrap=%0d exp=%h, want all 0", locked, err_pulse, restart_pulse, err_cnt, wrap_cnt, expected);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_lock();
        send(4'h3);
        checks++;
        if (locked !== 1'b0 || expected !== 4'h4) begin
            errors++;
            $display("FAIL lock_first: got locked=%b exp=%h, want 0/4", locked, expected);
        end
        send(4'h4);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_mid: got locked=%b, want 0", locked);
        end
        send(4'h5);
        checks++;
        if (locked !== 1'b1 || expected !== 4'h6 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL lock_done: got locked=%b exp=%h err=%0d, want 1/6/0", locked, expected, err_cnt);
        end
    endtask

    task automatic test_wrap();
        for (int v = 6; v < 18; v++) begin
            send(4'(v));
            checks++;
            if (err_pulse !== 1'b0 || locked !== 1'b1) begin
                errors++;
                $display("FAIL wrap_run[%0d]: got ep=%b locked=%b, want 0/1", v, err_pulse, locked);
            end
            if (v == 16) begin
                checks++;
                if (wrap_cnt !== 8'd1) begin
                    errors++;
                    $display("FAIL wrap_count: got %0d, want 1", wrap_cnt);
                end
            end
        end
        checks++;
        if (expected !== 4'h2 || wrap_cnt !== 8'd1) begin
            errors++;
            $display("FAIL wrap_end: got exp=%h wrap=%0d, want 2/1", expected, wrap_cnt);
        end
    endtask

    task automatic test_error();
        for (int v = 2; v < 7; v++) send(4'(v));
        checks++;
        if (expected !== 4'h7 || locked !== 1'b1) begin
            errors++;
            $display("FAIL err_pre: got exp=%h locked=%b, want 7/1", expected, locked);
        end
        send(4'h9);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || expected !== 4'hA) begin
            errors++;
            $display("FAIL err_hit: got ep=%b err=%0d locked=%b exp=%h, want 1/1/0/A", err_pulse, err_cnt, locked, expected);
        end
        idle();
        checks++;
        if (err_pulse !== 1'b0 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL err_pulse_drop: got ep=%b err=%0d, want 0/1", err_pulse, err_cnt);
        end
        send(4'hA);
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL err_resync_a: got locked=%b ep=%b, want 0/0", locked, err_pulse);
        end
        send(4'hB);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL err_relock: got locked=%b err=%0d, want 1/1", locked, err_cnt);
        end
    endtask

    task automatic test_restart();
        send(4'h0);
        checks++;
        if (restart_pulse !== 1'b1 || expected !== 4'h1 || locked !== 1'b1 || wrap_cnt !== 8'd1) begin
            errors++;
            $display("FAIL restart_c: got rp=%b exp=%h locked=%b wrap=%0d, want 1/1/1/1", restart_pulse, expected, locked, wrap_cnt);
        end
        for (int v = 1; v < 6; v++) send(4'(v));
        checks++;
        if (expected !== 4'h6 || restart_pulse !== 1'b0) begin
            errors++;
            $display("FAIL restart_pre: got exp=%h rp=%b, want 6/0", expected, restart_pulse);
        end
        send(4'h0);
        checks++;
        if (restart_pulse !== 1'b1 || expected !== 4'h1 || locked !== 1'b1 || err_cnt !== 8'd1 || wrap_cnt !== 8'd1 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL restart_6: got rp=%b exp=%h locked=%b err=%0d wrap=%0d ep=%b, want 1/1/1/1/1/0", restart_pulse, expected, locked, err_cnt, wrap_cnt, err_pulse);
        end
        idle();
        checks++;
        if (restart_pulse !== 1'b0) begin
            errors++;
            $display("FAIL restart_drop: got rp=%b, want 0", restart_pulse);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            logic [3:0] v;
            v = (i % 2 == 0) ? 4'h9 : 4'h2;
            send(v);
            send(v + 4'd1);
            send(v + 4'd2);
        end
        checks++;
        if (err_cnt !== 8'd255 || locked !== 1'b1 || expected !== 4'h5) begin
            errors++;
            $display("FAIL sat_full: got err=%0d locked=%b exp=%h, want 255/1/5", err_cnt, locked, expected);
        end
        clr_err = 1'b1;
        send(4'h9);
        clr_err = 1'b0;
        checks++;
        if (err_cnt !== 8'd1 || err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL sat_clr_err: got err=%0d ep=%b, want 1/1", err_cnt, err_pulse);
        end
    endtask

    task automatic test_reset_mid();
        send(4'hA);
        send(4'hB);
        checks++;
        if (locked !== 1'b1 || wrap_cnt !== 8'd1 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL mid_pre: got locked=%b wrap=%0d err=%0d, want 1/1/1", locked, wrap_cnt, err_cnt);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({locked, err_pulse, restart_pulse, err_cnt, wrap_cnt, expected} !== 23'd0) begin
            errors++;
            $display("FAIL mid_reset: got locked=%b ep=%b rp=%b err=%0d wrap=%0d exp=%h, want all 0", locked, err_pulse, restart_pulse, err_cnt, wrap_cnt, expected);
        end
        #2;
        reset = 1'b1;
        send(4'h5);
        checks++;
        if (locked !== 1'b0 || expected !== 4'h6 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL mid_sync: got locked=%b exp=%h ep=%b, want 0/6/0", locked, expected, err_pulse);
        end
        send(4'h6);
        send(4'h7);
        checks++;
        if (locked !== 1'b1 || expected !== 4'h8) begin
            errors++;
            $display("FAIL mid_relock: got locked=%b exp=%h, want 1/8", locked, expected);
        end
    endtask

    initial begin
        reset = 1'b0;
        valid = 1'b0;
        clr_err = 1'b0;
        q_in = 4'h0;
        test_reset();
        test_lock();
        test_wrap();
        test_error();
        test_restart();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
